// File: rtl/alu_decode_stage.sv
// RV32I ALU-class decode stage: decodes OP / OP-IMM / LUI / AUIPC into ALU controls
// and holds them in a one-entry valid/ready pipeline register.

package alu_decode_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_PASS = 4'd10
   } alu_op_e;

   localparam logic [1:0] ASEL_RS1  = 2'd0;
   localparam logic [1:0] ASEL_PC   = 2'd1;
   localparam logic [1:0] ASEL_ZERO = 2'd2;
   localparam logic       BSEL_RS2  = 1'b0;
   localparam logic       BSEL_IMM  = 1'b1;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   typedef struct packed {
      alu_op_e     alu_op;
      logic [1:0]  a_sel;
      logic        b_sel;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        we;
      logic        illegal;
   } dec_t;

   localparam dec_t DEC_RESET = '{
      alu_op:  ALU_ADD,
      a_sel:   ASEL_RS1,
      b_sel:   BSEL_RS2,
      imm:     32'd0,
      rs1:     5'd0,
      rs2:     5'd0,
      rd:      5'd0,
      we:      1'b0,
      illegal: 1'b0
   };

endpackage

module alu_decode_stage
   import alu_decode_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output logic        valid_o,
   input  logic        ready_i,
   output alu_op_e     alu_op_o,
   output logic [1:0]  a_sel_o,
   output logic        b_sel_o,
   output logic [31:0] imm_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic        we_o,
   output logic        illegal_o,
   output logic [31:0] pc_o
);

   localparam int Width = 32;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [Width-1:0] imm_i_type;
   logic [Width-1:0] imm_u_type;
   logic [Width-1:0] imm_shamt;
   logic             legal;
   logic             accept;

   dec_t             dec;
   dec_t             held;
   logic             held_vld;
   logic [Width-1:0] held_pc;

   assign opcode     = instr_i[6:0];
   assign funct3     = instr_i[14:12];
   assign funct7     = instr_i[31:25];
   assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_u_type = {instr_i[31:12], 12'd0};
   assign imm_shamt  = {27'd0, instr_i[24:20]};

   // funct3 -> operation for the encodings shared by OP (funct7 = 0) and OP-IMM
   function automatic alu_op_e base_op(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         3'd0:    op = ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   always_comb begin
      dec         = DEC_RESET;
      dec.rs1     = instr_i[19:15];
      dec.rs2     = instr_i[24:20];
      dec.rd      = instr_i[11:7];
      legal       = 1'b1;

      case (opcode)
         OPC_OP: begin
            dec.a_sel = ASEL_RS1;
            dec.b_sel = BSEL_RS2;
            case (funct7)
               7'h00: dec.alu_op = base_op(funct3);
               7'h20: begin
                  if (funct3 == 3'd0)      dec.alu_op = ALU_SUB;
                  else if (funct3 == 3'd5) dec.alu_op = ALU_SRA;
                  else                     legal = 1'b0;
               end
               default: legal = 1'b0;
            endcase
         end

         OPC_OPIMM: begin
            dec.a_sel = ASEL_RS1;
            dec.b_sel = BSEL_IMM;
            case (funct3)
               3'd1: begin
                  dec.imm    = imm_shamt;
                  dec.alu_op = ALU_SLL;
                  if (funct7 != 7'h00) legal = 1'b0;
               end
               3'd5: begin
                  dec.imm = imm_shamt;
                  if (funct7 == 7'h00)      dec.alu_op = ALU_SRL;
                  else if (funct7 == 7'h20) dec.alu_op = ALU_SRA;
                  else                      legal = 1'b0;
               end
               default: begin
                  dec.imm    = imm_i_type;
                  dec.alu_op = base_op(funct3);
               end
            endcase
         end

         OPC_LUI: begin
            dec.alu_op = ALU_ADD;
            dec.a_sel  = ASEL_ZERO;
            dec.b_sel  = BSEL_IMM;
            dec.imm    = imm_u_type;
         end

         OPC_AUIPC: begin
            dec.alu_op = ALU_ADD;
            dec.a_sel  = ASEL_PC;
            dec.b_sel  = BSEL_IMM;
            dec.imm    = imm_u_type;
         end

         default: legal = 1'b0;
      endcase

      // Illegal words still flow down the pipe, but as a harmless ADD rs1+rs2
      if (!legal) begin
         dec.alu_op = ALU_ADD;
         dec.a_sel  = ASEL_RS1;
         dec.b_sel  = BSEL_RS2;
         dec.imm    = '0;
      end
      dec.illegal = !legal;
      dec.we      = legal && (dec.rd != 5'd0);
   end

   assign ready_o = !held_vld || ready_i;
   assign accept  = valid_i && ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         held_vld <= 1'b0;
         held     <= DEC_RESET;
         held_pc  <= '0;
      end else begin
         if (flush_i)      held_vld <= 1'b0;
         else if (accept)  held_vld <= 1'b1;
         else if (ready_i) held_vld <= 1'b0;

         // Payload only moves on a real accept; a flushed word never lands
         if (accept && !flush_i) begin
            held    <= dec;
            held_pc <= pc_i;
         end
      end
   end

   assign valid_o   = held_vld;
   assign alu_op_o  = held.alu_op;
   assign a_sel_o   = held.a_sel;
   assign b_sel_o   = held.b_sel;
   assign imm_o     = held.imm;
   assign rs1_o     = held.rs1;
   assign rs2_o     = held.rs2;
   assign rd_o      = held.rd;
   assign we_o      = held.we;
   assign illegal_o = held.illegal;
   assign pc_o      = held_pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed + randomized bench for alu_decode_stage against a spec-level decode model
// and a one-entry pipeline model.

module tb_alu_decode_stage;
   import alu_decode_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] instr;
   logic [31:0] pc_in;
   logic        valid_out;
   logic        ready_in;
   alu_op_e     alu_op;
   logic [1:0]  a_sel;
   logic        b_sel;
   logic [31:0] imm;
   logic [4:0]  rs1, rs2, rd;
   logic        we;
   logic        illegal;
   logic [31:0] pc_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_decode_stage dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .flush_i   (flush),
      .valid_i   (valid_in),
      .ready_o   (ready_out),
      .instr_i   (instr),
      .pc_i      (pc_in),
      .valid_o   (valid_out),
      .ready_i   (ready_in),
      .alu_op_o  (alu_op),
      .a_sel_o   (a_sel),
      .b_sel_o   (b_sel),
      .imm_o     (imm),
      .rs1_o     (rs1),
      .rs2_o     (rs2),
      .rd_o      (rd),
      .we_o      (we),
      .illegal_o (illegal),
      .pc_o      (pc_out)
   );

   typedef struct {
      alu_op_e     op;
      logic [1:0]  a;
      logic        b;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic        we;
      logic        ill;
      logic [31:0] pc;
   } exp_t;

   // Reference decode written from the ISA rules
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
      exp_t    e;
      alu_op_e tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      int      f3  = int'(ins[14:12]);
      int      f7  = int'(ins[31:25]);
      int      opc = int'(ins[6:0]);
      bit      ok  = 1'b0;
      bit      shift;
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd  = ins[11:7];
      e.pc  = pc;
      e.op  = ALU_ADD;
      e.a   = 2'd0;
      e.b   = 1'b0;
      e.imm = 32'd0;
      if (opc == 'h33) begin
         ok   = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
         e.op = (f7 == 32) ? ((f3 == 0) ? ALU_SUB : ALU_SRA) : tab[f3];
      end else if (opc == 'h13) begin
         shift = (f3 == 1 || f3 == 5);
         ok    = !shift || f7 == 0 || (f3 == 5 && f7 == 32);
         e.op  = (shift && f7 == 32) ? ALU_SRA : tab[f3];
         e.b   = 1'b1;
         e.imm = shift ? ((ins >> 20) & 32'd31) : 32'($signed(ins) >>> 20);
      end else if (opc == 'h37 || opc == 'h17) begin
         ok    = 1'b1;
         e.a   = (opc == 'h37) ? 2'd2 : 2'd1;
         e.b   = 1'b1;
         e.imm = ins & 32'hFFFF_F000;
      end
      if (!ok) begin
         e.op  = ALU_ADD;
         e.a   = 2'd0;
         e.b   = 1'b0;
         e.imm = 32'd0;
      end
      e.ill = !ok;
      e.we  = ok && (e.rd != 5'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".op"},  32'(alu_op), 32'(e.op));
      chk({tag, ".a"},   32'(a_sel),  32'(e.a));
      chk({tag, ".b"},   32'(b_sel),  32'(e.b));
      chk({tag, ".imm"}, imm,         e.imm);
      chk({tag, ".rs1"}, 32'(rs1),    32'(e.rs1));
      chk({tag, ".rs2"}, 32'(rs2),    32'(e.rs2));
      chk({tag, ".rd"},  32'(rd),     32'(e.rd));
      chk({tag, ".we"},  32'(we),     32'(e.we));
      chk({tag, ".ill"}, 32'(illegal), 32'(e.ill));
      chk({tag, ".pc"},  pc_out,      e.pc);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".valid"}, 32'(valid_out), 32'd0);
      chk({tag, ".ready"}, 32'(ready_out), 32'd1);
      chk({tag, ".op"},    32'(alu_op),    32'(ALU_ADD));
      chk({tag, ".a"},     32'(a_sel),     32'd0);
      chk({tag, ".b"},     32'(b_sel),     32'd0);
      chk({tag, ".imm"},   imm,            32'd0);
      chk({tag, ".pc"},    pc_out,         32'd0);
      chk({tag, ".regs"},  32'({rs1, rs2, rd}), 32'd0);
      chk({tag, ".we"},    32'(we),        32'd0);
      chk({tag, ".ill"},   32'(illegal),   32'd0);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl);
      valid_in = v;
      instr    = ins;
      pc_in    = pc;
      ready_in = rdy;
      flush    = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] base = $urandom;
      logic [6:0]  opc;
      logic [6:0]  f7;
      int          sel  = $urandom_range(0, 9);
      int          fsel = $urandom_range(0, 3);
      if (sel <= 3)      opc = 7'h33;
      else if (sel <= 6) opc = 7'h13;
      else if (sel == 7) opc = 7'h37;
      else if (sel == 8) opc = 7'h17;
      else               opc = base[6:0];
      if (fsel <= 1)      f7 = 7'h00;
      else if (fsel == 2) f7 = 7'h20;
      else                f7 = base[31:25];
      return {f7, base[24:7], opc};
   endfunction

   initial begin
      exp_t        e;
      bit          m_vld;
      exp_t        m_ent;
      logic [31:0] ins, pcv;
      bit          v, r, f;

      rst_n = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      #12;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic decode, one instruction per cycle
      drive(1'b1, 32'h0020_81B3, 32'h0, 1'b1, 1'b0);
      tick();
      chk("add.valid", 32'(valid_out), 32'd1);
      chk("add.op",    32'(alu_op),    32'(ALU_ADD));
      chk("add.sel",   32'({a_sel, b_sel}), 32'd0);
      chk("add.rs1",   32'(rs1), 32'd1);
      chk("add.rs2",   32'(rs2), 32'd2);
      chk("add.rd",    32'(rd),  32'd3);
      chk("add.we",    32'(we),  32'd1);

      drive(1'b1, 32'h4020_81B3, 32'h4, 1'b1, 1'b0);
      tick();
      chk("sub.op", 32'(alu_op), 32'(ALU_SUB));

      drive(1'b1, 32'hFFF0_0293, 32'h8, 1'b1, 1'b0);
      tick();
      chk("addi.op",  32'(alu_op), 32'(ALU_ADD));
      chk("addi.b",   32'(b_sel),  32'd1);
      chk("addi.imm", imm,         32'hFFFF_FFFF);
      chk("addi.rd",  32'(rd),     32'd5);
      chk("addi.we",  32'(we),     32'd1);

      drive(1'b1, 32'h4030_D093, 32'hC, 1'b1, 1'b0);
      tick();
      chk("srai.op",  32'(alu_op), 32'(ALU_SRA));
      chk("srai.imm", imm,         32'h0000_0003);

      drive(1'b1, 32'h1234_53B7, 32'h10, 1'b1, 1'b0);
      tick();
      chk("lui.a",   32'(a_sel), 32'd2);
      chk("lui.imm", imm,        32'h1234_5000);
      chk("lui.rd",  32'(rd),    32'd7);

      drive(1'b1, 32'h0000_1097, 32'h100, 1'b1, 1'b0);
      tick();
      chk("auipc.a",   32'(a_sel), 32'd1);
      chk("auipc.pc",  pc_out,     32'h100);
      chk("auipc.imm", imm,        32'h0000_1000);

      drive(1'b1, 32'h0000_0000, 32'h104, 1'b1, 1'b0);
      tick();
      chk("zero.ill",   32'(illegal),   32'd1);
      chk("zero.we",    32'(we),        32'd0);
      chk("zero.op",    32'(alu_op),    32'(ALU_ADD));
      chk("zero.valid", 32'(valid_out), 32'd1);

      drive(1'b1, 32'h0220_81B3, 32'h108, 1'b1, 1'b0);
      tick();
      chk("f7bad.ill", 32'(illegal), 32'd1);

      drive(1'b1, 32'h0020_8033, 32'h10C, 1'b1, 1'b0);
      tick();
      chk("addx0.we",  32'(we),      32'd0);
      chk("addx0.ill", 32'(illegal), 32'd0);

      // Stall for 3 cycles, then release: B must appear exactly once
      drive(1'b1, 32'hFFF0_0293, 32'h200, 1'b1, 1'b0);
      tick();
      e = model(32'hFFF0_0293, 32'h200);
      drive(1'b1, 32'h0020_81B3, 32'h204, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall.ready", 32'(ready_out), 32'd0);
         tick();
         chk("stall.valid", 32'(valid_out), 32'd1);
         chk_all("stall", e);
      end
      drive(1'b1, 32'h0020_81B3, 32'h204, 1'b1, 1'b0);
      #1;
      chk("release.ready", 32'(ready_out), 32'd1);
      tick();
      chk("release.valid", 32'(valid_out), 32'd1);
      chk_all("release", model(32'h0020_81B3, 32'h204));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("drain.valid", 32'(valid_out), 32'd0);

      // Flush while stalled with a new word offered
      drive(1'b1, 32'h1234_53B7, 32'h300, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h0020_81B3, 32'h304, 1'b0, 1'b1);
      #1;
      chk("flush.ready", 32'(ready_out), 32'd0);
      tick();
      chk("flush.valid", 32'(valid_out), 32'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("flush.nodup", 32'(valid_out), 32'd0);

      // Asynchronous reset in the middle of a stall
      drive(1'b1, 32'h4030_D093, 32'h400, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h0020_81B3, 32'h404, 1'b0, 1'b0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("midreset");
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against a one-entry pipeline model
      m_vld = 1'b0;
      m_ent = model(32'd0, 32'd0);
      for (int c = 0; c < 600; c++) begin
         ins = rand_instr();
         pcv = $urandom;
         v   = ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 2) != 0);
         f   = ($urandom_range(0, 15) == 0);
         drive(v, ins, pcv, r, f);
         #1;
         chk("rnd.ready", 32'(ready_out), 32'(!m_vld || r));
         if (f)                      m_vld = 1'b0;
         else if (v && (!m_vld || r)) begin
            m_vld = 1'b1;
            m_ent = model(ins, pcv);
         end else if (r)             m_vld = 1'b0;
         tick();
         chk("rnd.valid", 32'(valid_out), 32'(m_vld));
         if (m_vld) chk_all("rnd", m_ent);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
